pool_block_sequencer: RTL

- Converts a raster-order feature-map stream (row by row, left to right) into 2x2-block order, so pooler_max2x2 receives four consecutive pixels per pooling window.
- Sits immediately upstream of pooler_max2x2, between the conv/ReLU output stream and the pooler.
- Buffers one even row in a line buffer. On the odd row it pairs each column pair with the buffered pixels and emits each block as four consecutive valid beats: TL, TR, BL, BR.

---
 rtl/cnn_pkg.sv | 22 ++
 rtl/line_buffer.sv | 30 +++
 rtl/pool_block_sequencer.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared types and sizing helpers for the CNN streaming blocks.
package cnn_pkg;

   typedef enum logic [2:0] {
      StFill,
      StPairL,
      StPairR,
      StEmit0,
      StEmit1,
      StEmit2,
      StEmit3
   } seq_state_e;

   function automatic int unsigned col_w(input int unsigned w);
      return $clog2(w);
   endfunction

   function automatic int unsigned row_w(input int unsigned h);
      return $clog2(h);
   endfunction

endpackage

// File: rtl/line_buffer.sv
// One-row pixel store: single write port, two combinational read ports.
module line_buffer
   import cnn_pkg::*;
#(
   parameter int unsigned N = 16,
   parameter int unsigned W = 8
) (
   input  logic                 clk_i,
   input  logic                 we_i,
   input  logic [col_w(W)-1:0]  waddr_i,
   input  logic [N-1:0]         wdata_i,
   input  logic [col_w(W)-1:0]  raddr_a_i,
   input  logic [col_w(W)-1:0]  raddr_b_i,
   output logic [N-1:0]         rdata_a_o,
   output logic [N-1:0]         rdata_b_o
);

   // Storage is deliberately unreset; every entry is written before it is read.
   logic [N-1:0] mem_q [W];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_a_o = mem_q[raddr_a_i];
   assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/pool_block_sequencer.sv
// Reorders a raster pixel stream into 2x2 blocks (TL, TR, BL, BR) for a max pooler.
module pool_block_sequencer
   import cnn_pkg::*;
#(
   parameter int unsigned N = 16,
   parameter int unsigned W = 8,
   parameter int unsigned H = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         valid_in,
   output logic         in_ready,
   input  logic [N-1:0] din,
   output logic [N-1:0] dout,
   output logic         valid_out,
   output logic         last_out
);

   localparam int unsigned ColW = col_w(W);
   localparam int unsigned RowW = row_w(H);
   localparam logic [ColW-1:0] ColLast = ColW'(W - 1);
   localparam logic [RowW-1:0] RowLast = RowW'(H - 1);

   seq_state_e state_q, state_d;
   logic [ColW-1:0] col_q, col_d;
   logic [RowW-1:0] row_q, row_d;
   logic [N-1:0] hold_l_q, hold_l_d;
   logic [N-1:0] hold_r_q, hold_r_d;
   logic [N-1:0] dout_q, dout_d;
   logic valid_q, valid_d;
   logic last_q, last_d;

   logic xfer;
   logic lb_we;
   logic [N-1:0] lb_left, lb_right;

   line_buffer #(
      .N (N),
      .W (W)
   ) u_line_buffer (
      .clk_i     (clk),
      .we_i      (lb_we),
      .waddr_i   (col_q),
      .wdata_i   (din),
      .raddr_a_i (col_q - 1'b1),
      .raddr_b_i (col_q),
      .rdata_a_o (lb_left),
      .rdata_b_o (lb_right)
   );

   assign in_ready = (state_q == StFill) || (state_q == StPairL) || (state_q == StPairR);
   assign xfer     = valid_in && in_ready;

   always_comb begin
      state_d  = state_q;
      col_d    = col_q;
      row_d    = row_q;
      hold_l_d = hold_l_q;
      hold_r_d = hold_r_q;
      dout_d   = dout_q;
      valid_d  = 1'b0;
      last_d   = 1'b0;
      lb_we    = 1'b0;

      unique case (state_q)
         StFill: begin
            if (xfer) begin
               lb_we = 1'b1;
               if (col_q == ColLast) begin
                  col_d   = '0;
                  row_d   = row_q + 1'b1;
                  state_d = StPairL;
               end else begin
                  col_d = col_q + 1'b1;
               end
            end
         end
         StPairL: begin
            if (xfer) begin
               hold_l_d = din;
               col_d    = col_q + 1'b1;
               state_d  = StPairR;
            end
         end
         StPairR: begin
            if (xfer) begin
               hold_r_d = din;
               state_d  = StEmit0;
            end
         end
         StEmit0: begin
            valid_d = 1'b1;
            dout_d  = lb_left;
            state_d = StEmit1;
         end
         StEmit1: begin
            valid_d = 1'b1;
            dout_d  = lb_right;
            state_d = StEmit2;
         end
         StEmit2: begin
            valid_d = 1'b1;
            dout_d  = hold_l_q;
            state_d = StEmit3;
         end
         StEmit3: begin
            valid_d = 1'b1;
            dout_d  = hold_r_q;
            last_d  = (row_q == RowLast) && (col_q == ColLast);
            if (col_q == ColLast) begin
               col_d   = '0;
               row_d   = (row_q == RowLast) ? '0 : row_q + 1'b1;
               state_d = StFill;
            end else begin
               col_d   = col_q + 1'b1;
               state_d = StPairL;
            end
         end
         default: state_d = StFill;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= StFill;
         col_q    <= '0;
         row_q    <= '0;
         hold_l_q <= '0;
         hold_r_q <= '0;
         dout_q   <= '0;
         valid_q  <= 1'b0;
         last_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         col_q    <= col_d;
         row_q    <= row_d;
         hold_l_q <= hold_l_d;
         hold_r_q <= hold_r_d;
         dout_q   <= dout_d;
         valid_q  <= valid_d;
         last_q   <= last_d;
      end
   end

   assign dout      = dout_q;
   assign valid_out = valid_q;
   assign last_out  = last_q;

endmodule
